// File: rtl/timer1_compare_unit.sv
// Timer_1 time base and compare stage: prescaler, auto-reload up-counter, compare and sticky flags.
// Optional build macro TIMER1_PRELOAD_EN buffers ARR/CMP writes in shadow registers until overflow.
module timer1_compare_unit #(
    parameter int WIDTH     = 16,
    parameter int PSC_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [1:0]           wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    output logic [WIDTH-1:0]     cnt,
    output logic                 running,
    output logic                 cmp_match,
    output logic                 ovf,
    output logic                 cmp_flag,
    output logic                 ovf_flag
);

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_PSC  = 2'd1;
    localparam logic [1:0] ADDR_ARR  = 2'd2;
    localparam logic [1:0] ADDR_CMP  = 2'd3;

    logic                 enable;
    logic                 one_shot;
    logic [PSC_WIDTH-1:0] psc;
    logic [PSC_WIDTH-1:0] psc_cnt;
    logic [WIDTH-1:0]     arr;
    logic [WIDTH-1:0]     cmp;
    logic [WIDTH-1:0]     cnt_q;

    logic                 ctrl_wr;
    logic                 psc_wr;
    logic                 arr_wr;
    logic                 cmp_wr;
    logic                 clr_flags;
    logic                 restart;
    logic                 tick;
    logic                 wrap;
    logic [WIDTH-1:0]     cnt_next;
    logic [WIDTH-1:0]     arr_eff;
    logic [WIDTH-1:0]     cmp_eff;
    logic                 match_next;
    logic                 ovf_next;

    assign ctrl_wr   = wr_en && (wr_addr == ADDR_CTRL);
    assign psc_wr    = wr_en && (wr_addr == ADDR_PSC);
    assign arr_wr    = wr_en && (wr_addr == ADDR_ARR);
    assign cmp_wr    = wr_en && (wr_addr == ADDR_CMP);
    assign clr_flags = ctrl_wr && wr_data[2];
    assign restart   = ctrl_wr && wr_data[3];

    assign tick     = enable && (psc_cnt == psc);
    assign wrap     = tick && (cnt_q == arr);
    assign cnt_next = wrap ? '0 : cnt_q + WIDTH'(1);

    // A restart in the same cycle as a tick wins: the counter is zeroed and no pulse is emitted.
    assign match_next = tick && !restart && (cnt_next == cmp_eff) && (cmp_eff <= arr_eff);
    assign ovf_next   = wrap && !restart;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enable    <= 1'b0;
            one_shot  <= 1'b0;
            psc       <= '0;
            psc_cnt   <= '0;
            cnt_q     <= '0;
            cmp_match <= 1'b0;
            ovf       <= 1'b0;
            cmp_flag  <= 1'b0;
            ovf_flag  <= 1'b0;
        end else begin
            // Above PSC the prescaler free-runs to its maximum and wraps without a tick.
            if (!enable || tick) begin
                psc_cnt <= '0;
            end else begin
                psc_cnt <= psc_cnt + PSC_WIDTH'(1);
            end

            if (tick) begin
                cnt_q <= cnt_next;
            end
            if (wrap && one_shot) begin
                enable <= 1'b0;
            end

            cmp_match <= match_next;
            ovf       <= ovf_next;
            cmp_flag  <= cmp_match || (cmp_flag && !clr_flags);
            ovf_flag  <= ovf || (ovf_flag && !clr_flags);

            if (restart) begin
                cnt_q   <= '0;
                psc_cnt <= '0;
            end
            if (ctrl_wr) begin
                enable   <= wr_data[0];
                one_shot <= wr_data[1];
            end
            if (psc_wr) begin
                psc <= wr_data[PSC_WIDTH-1:0];
            end
        end
    end

`ifdef TIMER1_PRELOAD_EN
    logic [WIDTH-1:0] arr_sh;
    logic [WIDTH-1:0] cmp_sh;

    assign arr_eff = wrap ? arr_sh : arr;
    assign cmp_eff = wrap ? cmp_sh : cmp;

    // Shadows always capture writes; active values follow them at overflow or while stopped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arr_sh <= '0;
            cmp_sh <= '0;
            arr    <= '0;
            cmp    <= '0;
        end else begin
            if (wrap) begin
                arr <= arr_sh;
                cmp <= cmp_sh;
            end
            if (arr_wr) begin
                arr_sh <= wr_data;
                if (!enable) begin
                    arr <= wr_data;
                end
            end
            if (cmp_wr) begin
                cmp_sh <= wr_data;
                if (!enable) begin
                    cmp <= wr_data;
                end
            end
        end
    end
`else
    assign arr_eff = arr;
    assign cmp_eff = cmp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arr <= '0;
            cmp <= '0;
        end else begin
            if (arr_wr) begin
                arr <= wr_data;
            end
            if (cmp_wr) begin
                cmp <= wr_data;
            end
        end
    end
`endif

    assign cnt     = cnt_q;
    assign running = enable;

endmodule
